fb_pixel_writer_burst: RTL
==========================

Name: fb_pixel_writer_burst

Overview:
Second-generation framebuffer writer. It takes a single-clock pixel stream (x, y, 32-bit colour) and writes each pixel into one of two DDR3 framebuffers over Avalon-MM, using 64-bit words that hold 2 pixels each. It merges an even/odd pixel pair into one full-word write. It fills the selected buffer with a background colour using fixed-length bursts. It sits between the rasteriser output and the HPS SDRAM port.

Parameters:
ADDR_W, 29, Avalon word-address width (64-bit words).
FB0_BASE, 29'h0700_0000, word address of framebuffer 0.
FB1_BASE, 29'h0702_5800, word address of framebuffer 1.
H_RES, 640, pixels per line; must be even.
V_RES, 480, lines per frame.
BURST_LEN, 8, beats per fill burst; a power of two that divides H_RES*V_RES/2.
COALESCE, 1, 1 enables pair merging; 0 makes every pixel a half-word write.

Ports:
clock  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
buffer_select  in  1  0 selects FB0_BASE, 1 selects FB1_BASE; sampled on pixel accept and on fill start
fill_start  in  1  request to fill the selected buffer
fill_colour  in  32  background colour, sampled with fill_start
fill_busy  out  1  high from the cycle after fill accept until fill_done
fill_done  out  1  one-cycle pulse when the fill completes
pix_valid  in  1  pixel present
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_x  in  16  pixel column
pix_y  in  16  pixel line
pix_colour  in  32  pixel colour
pix_dropped  out  1  one-cycle pulse: out-of-range pixel was consumed
avm_address  out  ADDR_W  word address
avm_burstcount  out  8  beats in the transaction
avm_writedata  out  64  write data
avm_byteenable  out  8  byte lanes
avm_write  out  1  write request
avm_waitrequest  in  1  slave stall
state  out  4  current state, for debug

Behaviour:
- Reset values (the cycle after reset is sampled high): avm_write=0, avm_address=0, avm_burstcount=1, avm_writedata=0, avm_byteenable=0, pix_ready=0, fill_busy=0, fill_done=0, pix_dropped=0, state=IDLE(0).
- Reset mid-transaction abandons the transaction at once, including a partial burst. Reset has priority over every other input.
- States: IDLE(0), HOLD(1), PIX_WR(2), FILL_WR(3), DONE(4).
- pix_ready is high in IDLE, and in HOLD only for the matching pair pixel.
- Address arithmetic: word = base + ((pix_y*H_RES + pix_x) >> 1), computed at ADDR_W bits. Base is latched from buffer_select when the command is accepted.
- Lane selection: even x gives byteenable 8'h0F with colour in bits [31:0]. Odd x gives 8'hF0 with colour in bits [63:32]. Unused lanes are 0.
- IDLE, fill_start=1: latch fill_colour and base, set fill_busy, go to FILL_WR. fill_start has priority over a simultaneous pix_valid; that pixel is not accepted that cycle.
- IDLE, pixel accepted with pix_x>=H_RES or pix_y>=V_RES: no write, pulse pix_dropped, stay in IDLE.
- IDLE, in-range pixel accepted, COALESCE=1 and x even: latch it and go to HOLD.
- IDLE, any other in-range pixel: go to PIX_WR with a half-word write (burstcount=1).
- HOLD lasts exactly 1 cycle.
  - If pix_valid and pix_y equals the held y and pix_x equals held x+1: accept it and issue a full write (byteenable 8'hFF, {odd colour, even colour}).
  - Otherwise accept nothing and issue the half write of the held pixel.
  - HOLD always proceeds to PIX_WR.
- PIX_WR: avm_write=1. address, writedata and byteenable stay stable while avm_waitrequest=1. On the first cycle with waitrequest=0: drop write and go to IDLE.
- FILL_WR: issues H_RES*V_RES/(2*BURST_LEN) bursts.
  - Each burst has burstcount=BURST_LEN, address = base + burst_index*BURST_LEN, writedata {c,c}, byteenable 8'hFF.
  - address and burstcount stay constant for all beats of a burst; a beat advances only when waitrequest=0.
  - avm_write stays high across burst boundaries.
  - After the last beat is accepted: avm_write=0, go to DONE.
- DONE: fill_done=1 for one cycle, fill_busy=0, return to IDLE.
- fill_start while not in IDLE is ignored; it is not queued.
- buffer_select changes during a fill do not affect that fill.
- Throughput (zero waitrequest):
  - Single pixel: IDLE→PIX_WR→IDLE, 1 pixel per 2 cycles.
  - Merged pair: 2 pixels per 3 cycles.
  - Fill: 1 beat per cycle.

Test Plan:
- Single pixel, buffer_select=0, x=3, y=2, colour 32'hAABBCCDD, waitrequest=0 → one write: address 32'h0700_0281 (as 29-bit), byteenable 8'hF0, writedata 64'hAABBCCDD_00000000.
- Pair x=10 then x=11 on consecutive cycles, y=0, colours A and B, buffer_select=1 → one write: address 29'h0702_5805, byteenable 8'hFF, writedata {B,A}. x=10 followed by x=12 → two separate half writes.
- Pixel x=640, y=0 → pix_dropped pulses once, no avm_write, pix_ready back high next cycle.
- Fill buffer 1 with 32'h00112233, BURST_LEN=8 → 19200 bursts, first address 29'h0702_5800, last 29'h0704_AFF8, 153600 beats total, fill_done exactly once.
- Random waitrequest at 50% during a fill and during pixel writes → address, burstcount and data stable while stalled; beat count exact.
- Reset asserted on beat 3 of a burst → next cycle avm_write=0, state=IDLE, fill_busy=0, no fill_done. A new fill after reset completes normally.

Source files
------------

// File: rtl/fb_pixel_writer_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_writer_burst_if
// Purpose  : Bundles the pixel stream, fill control and Avalon-MM write port
//            of the framebuffer writer. The writer is the "master" (it drives
//            the Avalon-MM write side); the rasteriser/SDRAM side is "slave".
// Revision : 1.0 - initial release
// ============================================================================
interface fb_pixel_writer_burst_if #(
  parameter int ADDR_W = 29
);
  // Buffer / fill control
  logic              buffer_select;
  logic              fill_start;
  logic [31:0]       fill_colour;
  logic              fill_busy;
  logic              fill_done;
  // Pixel stream
  logic              pix_valid;
  logic              pix_ready;
  logic [15:0]       pix_x;
  logic [15:0]       pix_y;
  logic [31:0]       pix_colour;
  logic              pix_dropped;
  // Avalon-MM write master
  logic [ADDR_W-1:0] avm_address;
  logic [7:0]        avm_burstcount;
  logic [63:0]       avm_writedata;
  logic [7:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_waitrequest;
  // Debug
  logic [3:0]        state;

  modport master (
    input  buffer_select, fill_start, fill_colour,
    input  pix_valid, pix_x, pix_y, pix_colour,
    input  avm_waitrequest,
    output fill_busy, fill_done, pix_ready, pix_dropped,
    output avm_address, avm_burstcount, avm_writedata, avm_byteenable, avm_write,
    output state
  );

  modport slave (
    output buffer_select, fill_start, fill_colour,
    output pix_valid, pix_x, pix_y, pix_colour,
    output avm_waitrequest,
    input  fill_busy, fill_done, pix_ready, pix_dropped,
    input  avm_address, avm_burstcount, avm_writedata, avm_byteenable, avm_write,
    input  state
  );
endinterface
`default_nettype wire

// File: rtl/fb_pixel_writer_burst.sv
`default_nettype none
// ============================================================================
// Module   : fb_pixel_writer_burst
// Purpose  : Writes a pixel stream into one of two 64-bit-word framebuffers
//            over Avalon-MM, merging even/odd pixel pairs into full-word
//            writes, and fills a whole buffer with a colour using fixed
//            length bursts.
// Revision : 1.0 - initial release
// ============================================================================
module fb_pixel_writer_burst #(
  parameter int                ADDR_W    = 29,
  parameter logic [ADDR_W-1:0] FB0_BASE  = 29'h0700_0000,
  parameter logic [ADDR_W-1:0] FB1_BASE  = 29'h0702_5800,
  parameter int                H_RES     = 640,  // must be even
  parameter int                V_RES     = 480,
  parameter int                BURST_LEN = 8,    // power of two dividing H_RES*V_RES/2
  parameter int                COALESCE  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  fb_pixel_writer_burst_if.master       bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HOLD    = 4'd1,
    PIX_WR  = 4'd2,
    FILL_WR = 4'd3,
    DONE    = 4'd4
  } state_t;

  localparam int WORDS      = (H_RES * V_RES) / 2;
  localparam int N_BURSTS   = WORDS / BURST_LEN;
  localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W    = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(N_BURSTS - 1);
  localparam logic [15:0]        H_LIM      = 16'(H_RES);
  localparam logic [15:0]        V_LIM      = 16'(V_RES);

  state_t              st;
  logic [ADDR_W-1:0]   base;
  logic [15:0]         held_x;
  logic [15:0]         held_y;
  logic [31:0]         held_col;
  logic [BEAT_W-1:0]   beat;
  logic [BURST_W-1:0]  burst;
  logic                idle_rdy;   // IDLE is ready to take a pixel (low for one cycle after reset)

  logic [ADDR_W-1:0]   address;
  logic [7:0]          burstcount;
  logic [63:0]         writedata;
  logic [7:0]          byteenable;
  logic                write;
  logic                fill_busy;
  logic                fill_done;
  logic                pix_dropped;

  // Word offset of a pixel inside a buffer; two pixels share one 64-bit word.
  function automatic logic [ADDR_W-1:0] word_of(input logic [15:0] x, input logic [15:0] y);
    logic [ADDR_W-1:0] lin;
    lin = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    return lin >> 1;
  endfunction

  logic [ADDR_W-1:0] sel_base;
  logic              in_range;
  logic              pair_match;

  assign sel_base   = bus.buffer_select ? FB1_BASE : FB0_BASE;
  assign in_range   = (bus.pix_x < H_LIM) && (bus.pix_y < V_LIM);
  // The odd partner of a held even pixel is only taken in the HOLD cycle.
  assign pair_match = (st == HOLD) && bus.pix_valid &&
                      (bus.pix_y == held_y) && (bus.pix_x == held_x + 16'd1);

  // fill_start wins over a simultaneous pixel, so it masks readiness in IDLE.
  assign bus.pix_ready      = (idle_rdy && (st == IDLE) && !bus.fill_start) || pair_match;
  assign bus.avm_address    = address;
  assign bus.avm_burstcount = burstcount;
  assign bus.avm_writedata  = writedata;
  assign bus.avm_byteenable = byteenable;
  assign bus.avm_write      = write;
  assign bus.fill_busy      = fill_busy;
  assign bus.fill_done      = fill_done;
  assign bus.pix_dropped    = pix_dropped;
  assign bus.state          = st;

  // Main control FSM with registered Avalon and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= IDLE;
      base        <= '0;
      held_x      <= '0;
      held_y      <= '0;
      held_col    <= '0;
      beat        <= '0;
      burst       <= '0;
      idle_rdy    <= 1'b0;
      address     <= '0;
      burstcount  <= 8'd1;
      writedata   <= '0;
      byteenable  <= '0;
      write       <= 1'b0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      pix_dropped <= 1'b0;
    end else begin
      fill_done   <= 1'b0;
      pix_dropped <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.fill_start) begin
            base       <= sel_base;
            address    <= sel_base;
            burstcount <= 8'(BURST_LEN);
            writedata  <= {bus.fill_colour, bus.fill_colour};
            byteenable <= 8'hFF;
            write      <= 1'b1;
            beat       <= '0;
            burst      <= '0;
            fill_busy  <= 1'b1;
            idle_rdy   <= 1'b0;
            st         <= FILL_WR;
          end else if (!idle_rdy) begin
            idle_rdy <= 1'b1;
          end else if (bus.pix_valid) begin
            if (!in_range) begin
              pix_dropped <= 1'b1;
            end else if ((COALESCE != 0) && !bus.pix_x[0]) begin
              held_x   <= bus.pix_x;
              held_y   <= bus.pix_y;
              held_col <= bus.pix_colour;
              base     <= sel_base;
              idle_rdy <= 1'b0;
              st       <= HOLD;
            end else begin
              address    <= sel_base + word_of(bus.pix_x, bus.pix_y);
              burstcount <= 8'd1;
              byteenable <= bus.pix_x[0] ? 8'hF0 : 8'h0F;
              writedata  <= bus.pix_x[0] ? {bus.pix_colour, 32'h0} : {32'h0, bus.pix_colour};
              write      <= 1'b1;
              idle_rdy   <= 1'b0;
              st         <= PIX_WR;
            end
          end
        end
        HOLD: begin
          address    <= base + word_of(held_x, held_y);
          burstcount <= 8'd1;
          write      <= 1'b1;
          if (pair_match) begin
            byteenable <= 8'hFF;
            writedata  <= {bus.pix_colour, held_col};
          end else begin
            byteenable <= 8'h0F;
            writedata  <= {32'h0, held_col};
          end
          st <= PIX_WR;
        end
        PIX_WR: begin
          if (!bus.avm_waitrequest) begin
            write    <= 1'b0;
            idle_rdy <= 1'b1;
            st       <= IDLE;
          end
        end
        FILL_WR: begin
          if (!bus.avm_waitrequest) begin
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (burst == LAST_BURST) begin
                write     <= 1'b0;
                fill_busy <= 1'b0;
                fill_done <= 1'b1;
                st        <= DONE;
              end else begin
                // write stays high: the next burst starts on the very next beat
                burst   <= burst + BURST_W'(1);
                address <= address + ADDR_W'(BURST_LEN);
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        DONE: begin
          idle_rdy <= 1'b1;
          st       <= IDLE;
        end
        default: begin
          write <= 1'b0;
          st    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
